// File: rtl/dice_roll_scheduler.sv
// Round-robin scheduler sharing one LFSR dice engine (d4/d6/d8/d20) among NUM_REQ requesters.
// Optional completed-roll counter on roll_count is built when DICE_STATS_EN is defined.
module dice_roll_scheduler #(
    parameter int          NUM_REQ = 4,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [2*NUM_REQ-1:0]   die_sel,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   resp_valid,
    output logic [2:0]             resp_id,
    output logic [7:0]             resp_value,
    output logic [15:0]            roll_count
);

    if (SEED == 16'h0000) begin : g_bad_seed
        $error("dice_roll_scheduler: SEED must be nonzero");
    end
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("dice_roll_scheduler: NUM_REQ must be 2..8");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_REDUCE, ST_DONE} state_t;

    state_t             r_state;
    logic [15:0]        r_lfsr;
    logic [2:0]         r_rr_ptr;
    logic [2:0]         r_cur_id;
    logic [7:0]         r_acc;
    logic [7:0]         r_sides;
    logic [NUM_REQ-1:0] r_grant;
    logic               r_resp_valid;
    logic [2:0]         r_resp_id;
    logic [7:0]         r_resp_value;

    logic [7:0]         w_req8;
    logic [7:0]         w_sides_tbl [8];
    logic               w_found;
    logic [2:0]         w_pick;
    logic               w_finish;

    assign w_req8 = 8'(req);

    // Unused table slots beyond NUM_REQ keep the lookup index a full 3 bits wide.
    for (genvar gi = 0; gi < 8; gi++) begin : g_sides
        if (gi < NUM_REQ) begin : g_used
            assign w_sides_tbl[gi] = (die_sel[2*gi +: 2] == 2'b00) ? 8'd4 :
                                     (die_sel[2*gi +: 2] == 2'b01) ? 8'd6 :
                                     (die_sel[2*gi +: 2] == 2'b10) ? 8'd8 : 8'd20;
        end else begin : g_unused
            assign w_sides_tbl[gi] = 8'd4;
        end
    end

    // Scan farthest-to-nearest from rr_ptr so the last hit is the nearest requester.
    always_comb begin
        w_found = 1'b0;
        w_pick  = 3'd0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            logic [3:0] v_idx;
            v_idx = {1'b0, r_rr_ptr} + 4'(k);
            if (v_idx >= 4'(NUM_REQ)) begin
                v_idx = v_idx - 4'(NUM_REQ);
            end
            if (w_req8[v_idx[2:0]]) begin
                w_found = 1'b1;
                w_pick  = v_idx[2:0];
            end
        end
    end

    assign w_finish = (r_state == ST_REDUCE) && (r_acc < r_sides);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_lfsr       <= SEED;
            r_rr_ptr     <= 3'(NUM_REQ - 1);
            r_cur_id     <= 3'd0;
            r_acc        <= 8'd0;
            r_sides      <= 8'd4;
            r_grant      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 3'd0;
            r_resp_value <= 8'd0;
        end else begin
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_grant  <= NUM_REQ'(1) << w_pick;
                        r_rr_ptr <= w_pick;
                        r_cur_id <= w_pick;
                        r_sides  <= w_sides_tbl[w_pick];
                        r_acc    <= r_lfsr[7:0];
                        r_state  <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    if (!w_finish) begin
                        r_acc <= r_acc - r_sides;
                    end else begin
                        r_resp_value <= r_acc + 8'd1;
                        r_resp_id    <= r_cur_id;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_resp_valid <= 1'b0;
                    r_grant      <= '0;
                    r_state      <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef DICE_STATS_EN
    logic [15:0] r_roll_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_roll_count <= 16'h0000;
        end else if (w_finish && (r_roll_count != 16'hFFFF)) begin
            r_roll_count <= r_roll_count + 16'd1;
        end
    end

    assign roll_count = r_roll_count;
`else
    assign roll_count = 16'h0000;
`endif

    assign grant      = r_grant;
    assign busy       = (r_state != ST_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_value = r_resp_value;

endmodule

// File: tb/tb_dice_roll_scheduler.sv
// Self-checking bench for dice_roll_scheduler: transaction-level reference model plus directed
// reset, latency, round-robin and die_sel-change cases, then a randomized range sweep.
module tb_dice_roll_scheduler;
    localparam int          NR     = 4;
    localparam logic [15:0] SEED_A = 16'h0001;
    localparam logic [15:0] SEED_B = 16'h00FF;
    localparam int          SWEEP  = 2500;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  req = '0, req_b = '0;
    logic [7:0]  die_sel = '0, die_b = '0;
    logic [3:0]  grant, grant_b;
    logic        busy, busy_b, resp_valid, rv_b;
    logic [2:0]  resp_id, id_b;
    logic [7:0]  resp_value, val_b;
    logic [15:0] roll_count, cnt_b;

    always #5 clk = ~clk;

    dice_roll_scheduler #(.NUM_REQ(NR), .SEED(SEED_A)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .die_sel(die_sel),
        .grant(grant), .busy(busy), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_value(resp_value), .roll_count(roll_count)
    );

    dice_roll_scheduler #(.NUM_REQ(NR), .SEED(SEED_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .die_sel(die_b),
        .grant(grant_b), .busy(busy_b), .resp_valid(rv_b), .resp_id(id_b),
        .resp_value(val_b), .roll_count(cnt_b)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_rolls = 0;

    // Reference model: one roll = grant, floor(a/sides) subtractions, result a%sides+1.
    logic [15:0] m_lfsr;
    logic [3:0]  m_grant;
    int          m_rr, m_left, m_id, m_sides, m_code, m_val, m_rid, m_rval, m_cnt;
    bit          m_active, m_rv;

    // Requester behaviour knobs
    logic [3:0]  want = '0;
    logic [3:0]  just_dropped = '0;
    int          p_raise = 0;
    bit          chg_die = 1'b0;
    int          obs_q[$];
    bit          seen [4][21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [7:0] v, input int i);
        logic [7:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int sides_of(input int code);
        case (code)
            0:       return 4;
            1:       return 6;
            2:       return 8;
            default: return 20;
        endcase
    endfunction

    task automatic model_reset();
        m_lfsr = SEED_A; m_grant = '0; m_rr = NR - 1; m_left = 0; m_id = 0;
        m_sides = 4; m_code = 0; m_val = 0; m_rid = 0; m_rval = 0; m_cnt = 0;
        m_active = 1'b0; m_rv = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] pre;
        logic [7:0]  t;
        int          pick;
        if (reset_n !== 1'b1) return;
        pre    = m_lfsr;
        m_lfsr = (pre >> 1) ^ (pre[0] ? 16'hB400 : 16'h0000);
        if (!m_active) begin
            pick = -1;
            for (int k = 1; k <= NR; k++) begin
                if (pick < 0 && bit_at(8'(req), (m_rr + k) % NR)) pick = (m_rr + k) % NR;
            end
            if (pick >= 0) begin
                t        = die_sel >> (2 * pick);
                m_code   = int'(t[1:0]);
                m_sides  = sides_of(m_code);
                m_left   = int'(pre[7:0]) / m_sides + 1;
                m_val    = int'(pre[7:0]) % m_sides + 1;
                m_id     = pick;
                m_rr     = pick;
                m_grant  = 4'(1 << pick);
                m_active = 1'b1;
            end
        end else if (m_rv) begin
            m_rv = 1'b0; m_grant = '0; m_active = 1'b0;
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_rv = 1'b1; m_rid = m_id; m_rval = m_val;
`ifdef DICE_STATS_EN
                if (m_cnt < 65535) m_cnt++;
`endif
            end
        end
    endtask

    // One clock: advance the model on the edge, compare on the falling edge, then act as the requesters.
    task automatic cycle();
        int v;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("grant", 32'(grant), 32'(m_grant));
        check("busy", 32'(busy), 32'(m_active));
        check("resp_valid", 32'(resp_valid), 32'(m_rv));
        check("resp_id", 32'(resp_id), 32'(m_rid));
        check("resp_value", 32'(resp_value), 32'(m_rval));
        check("roll_count", 32'(roll_count), 32'(m_cnt));
        just_dropped = '0;
        if (resp_valid === 1'b1) begin
            n_rolls++;
            v = int'(resp_value);
            $display("roll %0d: id=%0d d%0d -> %0d", n_rolls, resp_id, m_sides, v);
            obs_q.push_back(int'(resp_id));
            check("range", 32'(v >= 1 && v <= m_sides), 32'd1);
            if (v >= 1 && v <= 20) seen[m_code][v] = 1'b1;
            req          = req & ~(4'd1 << resp_id);
            just_dropped = 4'd1 << resp_id;
        end
        for (int i = 0; i < NR; i++) begin
            if (want[i] && !req[i] && !just_dropped[i] && $urandom_range(0, 99) < p_raise) begin
                req     = req | (4'd1 << i);
                die_sel = (die_sel & ~(8'h03 << (2 * i))) | (8'($urandom_range(0, 3)) << (2 * i));
            end else if (chg_die && req[i] && $urandom_range(0, 7) == 0) begin
                die_sel = (die_sel & ~(8'h03 << (2 * i))) | (8'($urandom_range(0, 3)) << (2 * i));
            end
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req = '0; req_b = '0; die_sel = '0; die_b = '0; want = '0; chg_die = 1'b0;
        model_reset();
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_value", 32'(resp_value), 32'd0);
        check("rst_roll_count", 32'(roll_count), 32'd0);
        repeat (2) cycle();
        reset_n = 1'b1;
    endtask

    // d20 on the SEED=1 instance and d6 on the SEED=0x00FF instance, both on the first edge after release.
    task automatic reset_and_first_roll();
        int b_edge, b_val, b_id;
        do_reset();
        req = 4'b0001; die_sel = 8'b0000_0011;
        req_b = 4'b0001; die_b = 8'b0000_0001;
        b_edge = -1; b_val = 0; b_id = 7;
        for (int n = 1; n <= 100; n++) begin
            cycle();
            if (n == 1) begin
                check("d20_grant", 32'(grant), 32'd1);
                check("d20_busy", 32'(busy), 32'd1);
                check("d20_no_early_valid", 32'(resp_valid), 32'd0);
                check("d6_grant", 32'(grant_b), 32'd1);
            end
            if (n == 2) begin
                check("d20_valid", 32'(resp_valid), 32'd1);
                check("d20_value", 32'(resp_value), 32'd2);
                check("d20_id", 32'(resp_id), 32'd0);
                check("model_pin_d20", 32'(m_rval), 32'd2);
            end
            if (rv_b === 1'b1 && b_edge < 0) begin
                b_edge = n - 1; b_val = int'(val_b); b_id = int'(id_b); req_b = '0;
            end
            if (n > 2 && b_edge >= 0) break;
        end
        check("d6_latency_edges", 32'(b_edge), 32'd43);
        check("d6_value", 32'(b_val), 32'd4);
        check("d6_id", 32'(b_id), 32'd0);
    endtask

    task automatic wait_results(input int cnt, input int budget, input string name);
        int c;
        c = 0;
        while (obs_q.size() < cnt && c < budget) begin
            cycle();
            c++;
        end
        check(name, 32'(obs_q.size()), 32'(cnt));
    endtask

    initial begin
        int sweep_start, got, faces;
        bit did_rst;
        #1;
        // Reset values, first-roll latency and LFSR seeding
        reset_and_first_roll();

        // Round robin from reset: all four held, each drops on its own result
        do_reset();
        req = 4'b1111; die_sel = 8'($urandom);
        obs_q.delete();
        wait_results(4, 1000, "rr_all_budget");
        for (int i = 0; i < 4; i++) check("rr_all_order", (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hFFFF, 32'(i));
        cycle();
        want = 4'b1001; p_raise = 100; req = 4'b1001;
        obs_q.delete();
        wait_results(3, 1000, "rr_1001_budget");
        check("rr_1001_order0", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hFFFF, 32'd0);
        check("rr_1001_order1", (obs_q.size() > 1) ? 32'(obs_q[1]) : 32'hFFFF, 32'd3);
        check("rr_1001_order2", (obs_q.size() > 2) ? 32'(obs_q[2]) : 32'hFFFF, 32'd0);
        want = '0;
        for (int c = 0; c < 300 && (m_active || req != 0); c++) cycle();
        check("rr_drain", 32'(m_active || req != 0), 32'd0);

        // die_sel changed right after the grant edge must not alter the die
        req = 4'b0001; die_sel = 8'b0000_0000;
        for (int c = 0; c < 10 && !m_active; c++) cycle();
        check("dsel_granted", 32'(m_active), 32'd1);
        die_sel = 8'b0000_0011;
        obs_q.delete();
        wait_results(1, 100, "dsel_budget");
        check("dsel_in_d4_range", 32'(resp_value >= 1 && resp_value <= 4), 32'd1);
        cycle();

        // Randomized sweep with one asynchronous reset mid-roll
        want = 4'b1111; p_raise = 30; chg_die = 1'b1; did_rst = 1'b0;
        sweep_start = n_rolls;
        for (int c = 0; c < 80000 && (n_rolls - sweep_start) < SWEEP; c++) begin
            cycle();
            if (!did_rst && (n_rolls - sweep_start) >= SWEEP / 2 && m_active && !m_rv && m_left >= 3) begin
                did_rst = 1'b1;
                reset_and_first_roll();
                want = 4'b1111; chg_die = 1'b1;
            end
        end
        check("sweep_rolls", 32'(n_rolls - sweep_start >= SWEEP), 32'd1);
        check("sweep_mid_reset_done", 32'(did_rst), 32'd1);
        for (int d = 0; d < 4; d++) begin
            faces = sides_of(d);
            got = 0;
            for (int f = 1; f <= faces; f++) if (seen[d][f]) got++;
            check("faces_seen", 32'(got), 32'(faces));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
